// File: rtl/mdu_seq_if.sv
// Handshake bus between a requester and the sequential multiply/divide unit.
// The requester uses the master modport, mdu_seq uses the slave modport.
interface mdu_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output in_valid, op, src1, src2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, 32 iterations, sign fix-up at the end.
module mdu_seq (
    input logic       clk,
    input logic       rst,
    mdu_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [31:0] aMag_q;
    logic [63:0] prod_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] result_q;

    logic        isDiv;
    logic        signed1;
    logic        signed2;
    logic        s1Neg;
    logic        s2Neg;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        negIn;
    logic        divZero;
    logic        divOvf;
    logic [31:0] bypassRes;

    logic [32:0] mulSum;
    logic [63:0] prod_d;
    logic [32:0] divShift;
    logic [32:0] remSub;
    logic        divGe;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [63:0] prodFinal;
    logic [31:0] quoFinal;
    logic [31:0] remFinal;
    logic [31:0] result_d;

    // Operand decode at acceptance: magnitudes, final sign and the bypass cases.
    always_comb begin
        isDiv     = bus.op[2];
        signed1   = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                    (bus.op == OP_DIV)  || (bus.op == OP_REM);
        signed2   = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        s1Neg     = signed1 & bus.src1[31];
        s2Neg     = signed2 & bus.src2[31];
        mag1      = s1Neg ? (~bus.src1 + 32'd1) : bus.src1;
        mag2      = s2Neg ? (~bus.src2 + 32'd1) : bus.src2;
        negIn     = (bus.op[2] & bus.op[1]) ? s1Neg : (s1Neg ^ s2Neg);
        divZero   = isDiv && (bus.src2 == 32'd0);
        divOvf    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.src1 == 32'h8000_0000) && (bus.src2 == 32'hFFFF_FFFF);
        bypassRes = 32'd0;
        if (divZero) begin
            bypassRes = bus.op[1] ? bus.src1 : 32'hFFFF_FFFF;
        end else if (divOvf) begin
            bypassRes = bus.op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration of both datapaths; only the one matching op_q is used.
    always_comb begin
        mulSum    = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? aMag_q : 32'd0)};
        prod_d    = {mulSum, prod_q[31:1]};
        divShift  = {rem_q, quo_q[31]};
        remSub    = divShift - {1'b0, aMag_q};
        divGe     = ~remSub[32];
        rem_d     = divGe ? remSub[31:0] : divShift[31:0];
        quo_d     = {quo_q[30:0], divGe};
        prodFinal = neg_q ? (~prod_d + 64'd1) : prod_d;
        quoFinal  = neg_q ? (~quo_d + 32'd1) : quo_d;
        remFinal  = neg_q ? (~rem_d + 32'd1) : rem_d;
        case (op_q)
            OP_MUL:                      result_d = prodFinal[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prodFinal[63:32];
            OP_DIV, 3'd5:                result_d = quoFinal;
            default:                     result_d = remFinal;
        endcase
    end

    // Control FSM and datapath registers; result only moves on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            aMag_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q   <= bus.op;
                        neg_q  <= negIn;
                        aMag_q <= isDiv ? mag2 : mag1;
                        prod_q <= {32'd0, mag2};
                        quo_q  <= mag1;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        if (divZero || divOvf) begin
                            result_q <= bypassRes;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    prod_q <= prod_d;
                    rem_q  <= rem_d;
                    quo_q  <= quo_d;
                    cnt_q  <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_q <= result_d;
                        cnt_q    <= '0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq: RV32M results, latencies, bypass cases,
// output backpressure and reset during an in-flight operation.
module tb_mdu_seq;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        int          expLat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mdu_seq_if bus ();

    mdu_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Compare one observed value against its required value.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Wait for in_ready, present one operation for the accepting edge, then scramble inputs.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("in_ready before issue", {31'd0, bus.in_ready}, 32'd1);
        bus.op       = op;
        bus.src1     = a;
        bus.src2     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = ~op;
        bus.src1     = ~a;
        bus.src2     = b ^ 32'h5A5A_0001;
    endtask

    // Count cycles from acceptance (first sample = cycle 1) until out_valid.
    task automatic waitResult(input logic [31:0] prevRes, output int lat, output logic [31:0] res,
                              output logic busyOk, output logic stableOk);
        lat      = 0;
        res      = '0;
        busyOk   = 1'b1;
        stableOk = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            if (!bus.busy || bus.in_ready) busyOk = 1'b0;
            if (bus.out_valid) begin
                lat = k;
                res = bus.result;
                break;
            end
            if (bus.result !== prevRes) stableOk = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [18];
        int          lat;
        logic [31:0] res;
        logic [31:0] prevRes;
        logic        busyOk;
        logic        stableOk;

        vecs[0]  = '{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{DIVU,   32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{REMU,   32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{REMU,   32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[13] = '{MULHSU, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[14] = '{DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[15] = '{DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[16] = '{REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[17] = '{REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1};

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = MUL;
        bus.src1      = 32'h0000_1234;
        bus.src2      = 32'h0000_0005;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        checkOutput("reset in_ready",  {31'd0, bus.in_ready},  32'd1);
        checkOutput("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("reset result",    bus.result,             32'd0);
        @(posedge clk);
        #1;
        checkOutput("idle after reset busy", {31'd0, bus.busy}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            prevRes = bus.result;
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitResult(prevRes, lat, res, busyOk, stableOk);
            checkOutput($sformatf("vec%0d result", i),  res, vecs[i].expRes);
            checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
            checkOutput($sformatf("vec%0d busy/in_ready while pending", i), {31'd0, busyOk}, 32'd1);
            checkOutput($sformatf("vec%0d result stable in CALC", i), {31'd0, stableOk}, 32'd1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d out_valid after handoff", i), {31'd0, bus.out_valid}, 32'd0);
        end

        bus.out_ready = 1'b0;
        prevRes = bus.result;
        applyStimulus(MUL, 32'd3, 32'd5);
        waitResult(prevRes, lat, res, busyOk, stableOk);
        checkOutput("bp result",  res, 32'd15);
        checkOutput("bp latency", lat, 32'd33);
        bus.in_valid = 1'b1;
        bus.op       = DIVU;
        bus.src1     = 32'd77;
        bus.src2     = 32'd0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp hold%0d out_valid", c), {31'd0, bus.out_valid}, 32'd1);
            checkOutput($sformatf("bp hold%0d result", c),    bus.result,             32'd15);
            checkOutput($sformatf("bp hold%0d in_ready", c),  {31'd0, bus.in_ready},  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("bp release in_ready",  {31'd0, bus.in_ready},  32'd1);
        checkOutput("bp release result",    bus.result,             32'd15);

        applyStimulus(MUL, 32'h0000_0011, 32'h0000_0022);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        checkOutput("mid-calc busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("abort in_ready",  {31'd0, bus.in_ready},  32'd1);
        checkOutput("abort busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("abort result",    bus.result,             32'd0);
        prevRes = bus.result;
        applyStimulus(MUL, 32'd3, 32'd4);
        waitResult(prevRes, lat, res, busyOk, stableOk);
        checkOutput("post-abort result",  res, 32'd12);
        checkOutput("post-abort latency", lat, 32'd33);
        checkOutput("post-abort busy",    {31'd0, busyOk}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have in_valid  input  1  requester presents an operation.
REQ-004 SHALL have in_ready  output  1  block can accept an operation.
REQ-005 SHALL have op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RV32M semantics).
REQ-006 SHALL have src1  input  32  rs1 operand (multiplicand / dividend).
REQ-007 SHALL have src2  input  32  rs2 operand (multiplier / divisor).
REQ-008 SHALL have out_valid  output  1  result available.
REQ-009 SHALL have out_ready  input  1  consumer takes result.
REQ-010 SHALL have result  output  32  operation result.
REQ-011 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement three states: IDLE, CALC, DONE.
REQ-013 SHALL drive in_ready = (state == IDLE); no acceptance in CALC or DONE.
REQ-014 SHALL accept when in_valid && in_ready, latching op, src1, src2; later input changes ignored until the next acceptance.
REQ-015 SHALL, on acceptance of a normal operation, go IDLE -> CALC, run exactly 32 CALC cycles (6-bit counter 0..31), then go to DONE; out_valid first high 33 cycles after the acceptance edge.
REQ-016 SHALL compute multiply by radix-2 shift-add on 32-bit magnitudes into a 64-bit product; sign fix-up after the last iteration: MULH both signed, MULHSU src1 signed/src2 unsigned, MULHU/MUL unsigned magnitudes (MUL returns product[31:0], others product[63:32]).
REQ-017 SHALL compute divide by radix-2 restoring division on magnitudes (33-bit partial remainder); quotient sign = sign(src1) XOR sign(src2), remainder sign = sign(src1) for DIV/REM; DIVU/REMU unsigned.
REQ-018 SHALL, for divisor 0, bypass CALC (IDLE -> DONE, out_valid one cycle after acceptance): DIV/DIVU result 0xFFFFFFFF, REM/REMU result = src1.
REQ-019 SHALL, for DIV/REM with src1 = 0x80000000 and src2 = 0xFFFFFFFF, bypass CALC: DIV result 0x80000000, REM result 0x00000000.
REQ-020 SHALL hold out_valid high and result stable in DONE until out_valid && out_ready; on that edge go DONE -> IDLE, out_valid low next cycle.
REQ-021 SHALL keep result from changing in any cycle other than the CALC->DONE or bypass transition edge.
REQ-022 SHALL not assert out_valid in IDLE or CALC.
REQ-023 SHALL tolerate in_valid held high while not in IDLE without side effect; next acceptance no earlier than the first IDLE cycle after handoff.

Reset
REQ-024 SHALL, on rst, enter IDLE next cycle regardless of state, discarding any in-flight operation.
REQ-025 SHALL reset outputs: in_ready 1 (IDLE), out_valid 0, busy 0, result 0x00000000; counter and internal registers 0.
REQ-026 SHALL ignore in_valid in any cycle where rst is high.

Verification
REQ-027 SHALL verify MUL src1=7, src2=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid first high exactly 33 cycles after acceptance, busy high cycles 1..33.
REQ-028 SHALL verify MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 SHALL verify DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-030 SHALL verify DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, out_valid one cycle after acceptance; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, same one-cycle latency.
REQ-031 SHALL verify backpressure: out_ready low 5 cycles in DONE -> out_valid and result stable, in_ready 0; out_ready high -> IDLE next cycle, in_ready 1.
REQ-032 SHALL verify rst asserted at CALC cycle 10 -> next cycle IDLE, out_valid 0, in_ready 1; a following MUL 3 x 4 returns 12 with normal 33-cycle latency.
